// File: rtl/max_reduce_int32.sv
// -----------------------------------------------------------------------------
// max_reduce_int32
//
// Streaming signed-maximum reduction. Elements arrive over a valid/ready
// input channel. A vector is closed by in_last. The block reports the
// maximum value, the zero-based index of its first occurrence, the number
// of elements accepted (saturating) and an overflow flag. The result is
// presented over a valid/ready output channel.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_data / in_last are valid this cycle
//   in_ready   : block accepts an element this cycle (0 while a result is held)
//   in_data    : signed element, WIDTH bits
//   in_last    : final element of the current vector
//   out_valid  : result fields are valid
//   out_ready  : downstream accepts the result
//   out_max    : signed maximum of the vector (0 while out_valid=0)
//   out_idx    : index of the first occurrence of the maximum (0 while idle)
//   out_count  : elements accepted, saturating at 2^IDX_WIDTH-1 (0 while idle)
//   out_ovf    : vector was longer than 2^IDX_WIDTH-1 elements (0 while idle)
//
// This file also holds max_reduce_int32_sgt, the signed greater-than
// comparator. Its IMPL_TYPE parameter is forwarded from the top level.
// -----------------------------------------------------------------------------

// Signed strict greater-than comparator.
//   IMPL_TYPE 1 : subtract-based (sign of a widened difference)
//   otherwise   : native signed relational operator
// Both produce the same result as a signed max operator: o_gt = (a > b).
module max_reduce_int32_sgt #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_gt
);

  logic [WIDTH:0] w_diff;

  // Comparator selection; the widened difference never overflows.
  always_comb begin
    w_diff = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
    case (IMPL_TYPE)
      32'sd1:  o_gt = ~w_diff[WIDTH] & (|w_diff);
      default: o_gt = ($signed(i_a) > $signed(i_b));
    endcase
  end

endmodule

module max_reduce_int32 #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0,
  parameter int IDX_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_max,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [IDX_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH-1:0] CNT_MAX  = {IDX_WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     DATA_ZERO = {WIDTH{1'b0}};

  // Working state
  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_acc;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [IDX_WIDTH-1:0] r_cnt;
  logic                 r_ovf;

  // Registered outputs
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_max;
  logic [IDX_WIDTH-1:0] r_out_idx;
  logic [IDX_WIDTH-1:0] r_out_count;
  logic                 r_out_ovf;

  // Next-state values
  logic [1:0]           w_state_nxt;
  logic [WIDTH-1:0]     w_acc_nxt;
  logic [IDX_WIDTH-1:0] w_idx_nxt;
  logic [IDX_WIDTH-1:0] w_cnt_nxt;
  logic                 w_ovf_nxt;
  logic                 w_xfer;
  logic                 w_gt;

  max_reduce_int32_sgt #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_sgt (
    .i_a  (in_data),
    .i_b  (r_acc),
    .o_gt (w_gt)
  );

  // A transfer needs both sides of the handshake. in_ready is registered
  // and already reflects the state, so no transfer can happen in DONE.
  assign w_xfer = in_valid & r_in_ready;

  // Next-state and accumulator update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_acc_nxt   = in_data;
          w_idx_nxt   = IDX_ZERO;
          w_cnt_nxt   = IDX_ONE;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = in_last ? S_DONE : S_ACCUM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_xfer) begin
          // After saturation the result is frozen on the first CNT_MAX
          // elements, so acc and idx always describe the same element.
          if (r_cnt == CNT_MAX) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + IDX_ONE;
            // Strict compare keeps the earlier index on a tie.
            if (w_gt) begin
              w_acc_nxt = in_data;
              w_idx_nxt = r_cnt;
            end else begin
              w_acc_nxt = r_acc;
              w_idx_nxt = r_idx;
            end
          end
          w_state_nxt = in_last ? S_DONE : S_ACCUM;
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Working-state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= DATA_ZERO;
      r_idx   <= IDX_ZERO;
      r_cnt   <= IDX_ZERO;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Output registers: loaded from the next-state values so they change
  // on the same edge as the FSM, and forced to zero outside DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_max   <= DATA_ZERO;
      r_out_idx   <= IDX_ZERO;
      r_out_count <= IDX_ZERO;
      r_out_ovf   <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != S_DONE);
      if (w_state_nxt == S_DONE) begin
        r_out_valid <= 1'b1;
        r_out_max   <= w_acc_nxt;
        r_out_idx   <= w_idx_nxt;
        r_out_count <= w_cnt_nxt;
        r_out_ovf   <= w_ovf_nxt;
      end else begin
        r_out_valid <= 1'b0;
        r_out_max   <= DATA_ZERO;
        r_out_idx   <= IDX_ZERO;
        r_out_count <= IDX_ZERO;
        r_out_ovf   <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_max   = r_out_max;
  assign out_idx   = r_out_idx;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_max_reduce_int32.sv
module tb_max_reduce_int32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_ovf;
  logic [31:0] out_max;
  logic [15:0] out_idx,   out_count;

  logic        in_ready2, out_valid2, out_ovf2;
  logic [31:0] out_max2;
  logic [1:0]  out_idx2,  out_count2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] vec[$];

  max_reduce_int32 #(.WIDTH(32), .IMPL_TYPE(0), .IDX_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  max_reduce_int32 #(.WIDTH(32), .IMPL_TYPE(1), .IDX_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_max(out_max2), .out_idx(out_idx2),
    .out_count(out_count2), .out_ovf(out_ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: max over the first min(n, cap) elements, first occurrence wins.
  task automatic ref_model(input int cap, output logic [31:0] mx,
                           output int idx, output int cnt, output bit ovf);
    int n;
    n   = vec.size();
    cnt = (n > cap) ? cap : n;
    ovf = (n > cap);
    mx  = vec[0];
    idx = 0;
    for (int i = 1; i < cnt; i++) begin
      if ($signed(vec[i]) > $signed(mx)) begin
        mx  = vec[i];
        idx = i;
      end
    end
  endtask

  // Drive every element of vec; returns at the negedge after the final transfer.
  task automatic push_vec(input bit bubbles, input bit mark_last);
    int w;
    for (int i = 0; i < vec.size(); i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      in_last  = mark_last && (i == vec.size() - 1);
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) begin
        n_checks++;
        $display("FAIL push_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, out_max, out_idx, out_count, out_ovf, in_ready} !==
        {1'b0, 32'd0, 16'd0, 16'd0, 1'b0, 1'b1})
      $display("FAIL reset_state: got v=%b max=%h idx=%0d cnt=%0d ovf=%b rdy=%b, required 0/0/0/0/0/1",
               out_valid, out_max, out_idx, out_count, out_ovf, in_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    vec = '{32'd3, 32'hFFFF_FFF9, 32'd12, 32'd12, 32'd5};
    out_ready = 1'b1;
    push_vec(1'b0, 1'b1);
    n_checks++;
    if ({out_valid, out_max, out_idx, out_count, out_ovf} !== {1'b1, 32'd12, 16'd2, 16'd5, 1'b0})
      $display("FAIL basic_result: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, required 1/12/2/5/0",
               out_valid, $signed(out_max), out_idx, out_count, out_ovf);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_max, out_idx, out_count, out_ovf, in_ready} !==
        {1'b0, 32'd0, 16'd0, 16'd0, 1'b0, 1'b1})
      $display("FAIL basic_drain: got v=%b max=%h rdy=%b, required idle zeros with ready",
               out_valid, out_max, in_ready);
    else n_pass++;
  endtask

  task automatic test_negative_and_single;
    vec = '{32'h8000_0000, 32'hFFFF_FFFF};
    push_vec(1'b1, 1'b1);
    n_checks++;
    if ({out_valid, out_max, out_idx, out_count} !== {1'b1, 32'hFFFF_FFFF, 16'd1, 16'd2})
      $display("FAIL negative_result: got v=%b max=%h idx=%0d cnt=%0d, required 1/ffffffff/1/2",
               out_valid, out_max, out_idx, out_count);
    else n_pass++;
    @(negedge clk);
    vec = '{32'h7FFF_FFFF};
    push_vec(1'b0, 1'b1);
    n_checks++;
    if ({out_valid, out_max, out_idx, out_count, out_ovf} !== {1'b1, 32'h7FFF_FFFF, 16'd0, 16'd1, 1'b0})
      $display("FAIL single_result: got v=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1/7fffffff/0/1/0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] mx, d;
    int idx, cnt;
    bit ovf;
    vec = '{$urandom(), $urandom(), $urandom()};
    ref_model(65535, mx, idx, cnt, ovf);
    out_ready = 1'b0;
    push_vec(1'b0, 1'b1);
    d = $urandom();
    in_valid = 1'b1; in_data = d; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({out_valid, out_max, out_idx, out_count, out_ovf, in_ready} !==
          {1'b1, mx, idx[15:0], cnt[15:0], ovf, 1'b0})
        $display("FAIL hold_cycle%0d: got v=%b max=%h idx=%0d cnt=%0d rdy=%b, required 1/%h/%0d/%0d/0",
                 k, out_valid, out_max, out_idx, out_count, in_ready, mx, idx, cnt);
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_max, out_count, in_ready} !== {1'b0, 32'd0, 16'd0, 1'b1})
      $display("FAIL hold_release: got v=%b max=%h cnt=%0d rdy=%b, required 0/0/0/1",
               out_valid, out_max, out_count, in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if ({out_valid, out_max, out_idx, out_count} !== {1'b1, d, 16'd0, 16'd1})
      $display("FAIL next_vector_after_hold: got v=%b max=%h idx=%0d cnt=%0d, required 1/%h/0/1",
               out_valid, out_max, out_idx, out_count, d);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    vec = '{32'd100, 32'd200};
    push_vec(1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({out_valid, out_max, out_count, in_ready} !== {1'b0, 32'd0, 16'd0, 1'b1})
      $display("FAIL reset_mid_idle: got v=%b max=%h cnt=%0d rdy=%b, required 0/0/0/1",
               out_valid, out_max, out_count, in_ready);
    else n_pass++;
    vec = '{32'd9};
    push_vec(1'b0, 1'b1);
    n_checks++;
    if ({out_valid, out_max, out_idx, out_count, out_ovf} !== {1'b1, 32'd9, 16'd0, 16'd1, 1'b0})
      $display("FAIL reset_mid_result: got v=%b max=%0d idx=%0d cnt=%0d, required 1/9/0/1",
               out_valid, out_max, out_idx, out_count);
    else n_pass++;
    // Reset while a result is held in DONE discards it.
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    n_checks++;
    if ({out_valid, out_max, out_count, in_ready} !== {1'b0, 32'd0, 16'd0, 1'b1})
      $display("FAIL reset_in_done: got v=%b max=%h cnt=%0d rdy=%b, required 0/0/0/1",
               out_valid, out_max, out_count, in_ready);
    else n_pass++;
  endtask

  task automatic test_overflow;
    logic [31:0] mx;
    int idx, cnt;
    bit ovf;
    vec = '{32'd4, 32'd7, 32'd7, 32'd1, 32'd50};
    ref_model(3, mx, idx, cnt, ovf);
    push_vec(1'b0, 1'b1);
    n_checks++;
    if ({out_valid2, out_max2, out_idx2, out_count2, out_ovf2} !==
        {1'b1, mx, idx[1:0], cnt[1:0], ovf})
      $display("FAIL ovf_narrow: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, required 1/%0d/%0d/%0d/%b",
               out_valid2, out_max2, out_idx2, out_count2, out_ovf2, mx, idx, cnt, ovf);
    else n_pass++;
    n_checks++;
    if ({out_valid, out_max, out_idx, out_count, out_ovf} !== {1'b1, 32'd50, 16'd4, 16'd5, 1'b0})
      $display("FAIL ovf_wide: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, required 1/50/4/5/0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] mx, mx2;
    int idx, cnt, idx2, cnt2, len;
    bit ovf, ovf2;
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(1, 8);
      vec = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 0) vec.push_back($urandom());
        else vec.push_back(32'($urandom_range(0, 6)) - 32'd3);
      end
      ref_model(65535, mx, idx, cnt, ovf);
      ref_model(3, mx2, idx2, cnt2, ovf2);
      out_ready = ($urandom_range(0, 1) == 1);
      push_vec(1'b1, 1'b1);
      n_checks++;
      if ({out_valid, out_max, out_idx, out_count, out_ovf} !==
          {1'b1, mx, idx[15:0], cnt[15:0], ovf})
        $display("FAIL random%0d_wide: got v=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1/%h/%0d/%0d/%b",
                 t, out_valid, out_max, out_idx, out_count, out_ovf, mx, idx, cnt, ovf);
      else n_pass++;
      n_checks++;
      if ({out_valid2, out_max2, out_idx2, out_count2, out_ovf2, in_ready2} !==
          {1'b1, mx2, idx2[1:0], cnt2[1:0], ovf2, 1'b0})
        $display("FAIL random%0d_narrow: got v=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1/%h/%0d/%0d/%b",
                 t, out_valid2, out_max2, out_idx2, out_count2, out_ovf2, mx2, idx2, cnt2, ovf2);
      else n_pass++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_max, out_idx, out_count, out_ovf, in_ready} !==
          {1'b0, 32'd0, 16'd0, 16'd0, 1'b0, 1'b1})
        $display("FAIL random%0d_drain: got v=%b max=%h rdy=%b, required idle zeros with ready",
                 t, out_valid, out_max, in_ready);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative_and_single();
    test_backpressure();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/max_reduce_int32.md
MAX_REDUCE_INT32 -- requirements
Module: max_reduce_int32

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, two's-complement signed.
REQ-002 SHALL have parameter IMPL_TYPE, default 0: implementation selector, passed unchanged to the signed greater-than comparator.
REQ-003 SHALL have parameter IDX_WIDTH, default 16: width of the element index and count fields.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: in_data/in_last are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts an element this cycle.
REQ-008 SHALL have port in_data, input, WIDTH: signed element.
REQ-009 SHALL have port in_last, input, 1: final element of the current vector.
REQ-010 SHALL have port out_valid, output, 1: result fields are valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port out_max, output, WIDTH: signed maximum of the vector.
REQ-013 SHALL have port out_idx, output, IDX_WIDTH: zero-based position of the first occurrence of the maximum.
REQ-014 SHALL have port out_count, output, IDX_WIDTH: number of elements accepted, saturating.
REQ-015 SHALL have port out_ovf, output, 1: vector length exceeded 2^IDX_WIDTH-1 elements.

Function
REQ-016 SHALL implement the three-state FSM IDLE (no element held), ACCUM (running max held), DONE (result presented).
REQ-017 SHALL transfer an input element only on a cycle where in_valid and in_ready are both 1.
REQ-018 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in DONE.
REQ-019 SHALL, on a transfer in IDLE: acc <= in_data, idx <= 0, cnt <= 1, ovf <= 0; next state ACCUM, or DONE if in_last=1.
REQ-020 SHALL, on a transfer in ACCUM, compare in_data > acc strictly signed, using the same semantics as the signed max operator.
REQ-021 SHALL, on that transfer, load acc <= in_data and idx <= cnt if in_data > acc, and otherwise hold acc and idx.
REQ-022 SHALL keep the earlier index on a tie, so equal values never update acc or idx.
REQ-023 SHALL increment cnt by 1 on each ACCUM transfer; when cnt is already 2^IDX_WIDTH-1, cnt SHALL hold, ovf SHALL be set and stay set, and idx updates SHALL stop.
REQ-024 SHALL move from ACCUM to DONE on a transfer with in_last=1; that last element SHALL be included in the result.
REQ-025 SHALL drive out_valid = 1 exactly while in DONE, with out_max=acc, out_idx=idx, out_count=cnt and out_ovf=ovf held stable.
REQ-026 SHALL have a latency of one cycle: out_valid rises in the cycle after the in_last transfer.
REQ-027 SHALL, in DONE with out_ready=1, return to IDLE on the next edge; with out_ready=0 it SHALL hold DONE and all outputs.
REQ-028 SHALL NOT allow an input transfer in the cycle DONE is left; the next vector's first element is accepted in IDLE at the earliest.
REQ-029 SHALL treat in_valid=0 cycles in ACCUM as bubbles: no state change.
REQ-030 SHALL treat a single-element vector (in_last on the IDLE transfer) as valid: result is that element, idx 0, count 1.
REQ-031 SHALL drive out_max, out_idx, out_count and out_ovf to 0 whenever out_valid=0.

Reset
REQ-032 SHALL, on a clock edge with rst_n=0, set state=IDLE and acc, idx, cnt, ovf=0, giving out_valid=0, all result outputs 0 and in_ready=1 in the next cycle.
REQ-033 SHALL, if reset is asserted mid-vector or in DONE, discard the partial or unconsumed result with no output transfer.

Verification
REQ-034 SHALL cover stream 3, -7, 12, 12, 5(last) with out_ready=1 -> out_valid one cycle after the last beat; out_max=12, out_idx=2, out_count=5, out_ovf=0.
REQ-035 SHALL cover all-negative stream 0x80000000, 0xFFFFFFFF(last) -> out_max=-1, out_idx=1, out_count=2.
REQ-036 SHALL cover single element 0x7FFFFFFF with in_last=1 -> out_max=0x7FFFFFFF, out_idx=0, out_count=1.
REQ-037 SHALL cover out_ready held 0 for 4 cycles in DONE -> outputs stable, in_ready=0, and a next-vector in_valid is not accepted until IDLE.
REQ-038 SHALL cover rst_n=0 for one edge after 2 of 4 elements, then a new vector 9(last) -> result out_max=9, out_count=1, with no stale result emitted.
REQ-039 SHALL cover IDX_WIDTH=2 with a 5-element stream whose maximum is in position 4 -> out_count=3, out_ovf=1, and out_idx equal to the index of the maximum among the first 3 elements.
